// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Opcode/funct constants, HALT word, FSM state and ALU-op enums
//               shared by the multicycle MIPS-subset core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   localparam logic [5:0] c_op_rtype = 6'd0;
   localparam logic [5:0] c_op_addi  = 6'd8;
   localparam logic [5:0] c_op_lw    = 6'd35;
   localparam logic [5:0] c_op_sw    = 6'd43;
   localparam logic [5:0] c_op_beq   = 6'd4;

   localparam logic [5:0] c_fn_add   = 6'd32;
   localparam logic [5:0] c_fn_sub   = 6'd34;
   localparam logic [5:0] c_fn_and   = 6'd36;
   localparam logic [5:0] c_fn_or    = 6'd37;
   localparam logic [5:0] c_fn_slt   = 6'd42;

   localparam logic [31:0] c_halt_word = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_t;

   // True when the instruction word belongs to the supported subset (HALT excluded)
   function automatic logic is_legal(input logic [31:0] ir);
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      if (op == c_op_rtype)
         return (fn == c_fn_add) || (fn == c_fn_sub) || (fn == c_fn_and) ||
                (fn == c_fn_or)  || (fn == c_fn_slt);
      return (op == c_op_addi) || (op == c_op_lw) || (op == c_op_sw) || (op == c_op_beq);
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : 32x32 register file, two asynchronous reads, one synchronous
//               write, register 0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] r_regs [32];

   // Clear all registers on reset; writes to register 0 are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         r_regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : r_regs[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : r_regs[raddr_b];

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_core
// Description : Multicycle MIPS-subset core with internal IMEM/DMEM, program
//               load port and start/halt control.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_core
   import mips_pkg::*;
#(
   parameter int IMEM_AW = 10,
   parameter int DMEM_AW = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               imem_we,
   input  logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_wdata,
   input  logic               start,
   output logic [31:0]        pc,
   output logic               halted,
   output logic               err,
   output logic               wb_valid,
   output logic [4:0]         wb_reg,
   output logic [31:0]        wb_data
);

   logic [31:0] r_imem [2**IMEM_AW];
   logic [31:0] r_dmem [2**DMEM_AW];

   state_t      r_state;
   logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu, r_mdr, r_wb_data;
   logic        r_halted, r_err, r_wb_valid;
   logic [4:0]  r_wb_reg;

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd, w_dest;
   logic [31:0] w_rf_a, w_rf_b, w_alu_b, w_alu_res, w_wb_val;
   alu_op_t     w_alu_op;

   assign w_op    = r_ir[31:26];
   assign w_rs    = r_ir[25:21];
   assign w_rt    = r_ir[20:16];
   assign w_rd    = r_ir[15:11];
   assign w_funct = r_ir[5:0];
   assign w_dest  = (w_op == c_op_rtype) ? w_rd : w_rt;
   assign w_wb_val = (w_op == c_op_lw) ? r_mdr : r_alu;

   regfile_2r1w u_rf (
      .clk     (clk),
      .rst     (rst),
      .raddr_a (w_rs),
      .raddr_b (w_rt),
      .rdata_a (w_rf_a),
      .rdata_b (w_rf_b),
      .we      (r_state == ST_WB),
      .waddr   (w_dest),
      .wdata   (w_wb_val)
   );

   // ALU operation select: only R-type uses funct, everything else adds
   always_comb begin
      w_alu_op = ALU_ADD;
      if (w_op == c_op_rtype) begin
         case (w_funct)
            c_fn_sub: w_alu_op = ALU_SUB;
            c_fn_and: w_alu_op = ALU_AND;
            c_fn_or:  w_alu_op = ALU_OR;
            c_fn_slt: w_alu_op = ALU_SLT;
            default:  w_alu_op = ALU_ADD;
         endcase
      end
   end

   assign w_alu_b = (w_op == c_op_rtype || w_op == c_op_beq) ? r_b : r_imm;

   // 32-bit wrap-around ALU; slt compares signed
   always_comb begin
      w_alu_res = r_a + w_alu_b;
      case (w_alu_op)
         ALU_SUB: w_alu_res = r_a - w_alu_b;
         ALU_AND: w_alu_res = r_a & w_alu_b;
         ALU_OR:  w_alu_res = r_a | w_alu_b;
         ALU_SLT: w_alu_res = ($signed(r_a) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
         default: w_alu_res = r_a + w_alu_b;
      endcase
   end

   // Program-load port, accepted only while the core is parked
   always_ff @(posedge clk) begin
      if (!rst && imem_we && (r_state == ST_IDLE || r_state == ST_HALT))
         r_imem[imem_addr] <= imem_wdata;
   end

   // Store path; reset on the same edge suppresses the write
   always_ff @(posedge clk) begin
      if (!rst && r_state == ST_MEM && w_op == c_op_sw)
         r_dmem[r_alu[DMEM_AW+1:2]] <= r_b;
   end

   // Sequencing FSM with registered status and writeback outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_ir       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_imm      <= '0;
         r_alu      <= '0;
         r_mdr      <= '0;
         r_halted   <= 1'b0;
         r_err      <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_reg   <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_valid <= 1'b0;
         case (r_state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  r_state  <= ST_FETCH;
                  r_pc     <= '0;
                  r_err    <= 1'b0;
                  r_halted <= 1'b0;
               end
            end
            ST_FETCH: begin
               r_ir    <= r_imem[r_pc[IMEM_AW+1:2]];
               r_pc    <= r_pc + 32'd4;
               r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               r_a   <= w_rf_a;
               r_b   <= w_rf_b;
               r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
               if (r_ir == c_halt_word) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end else if (!is_legal(r_ir)) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                  r_err    <= 1'b1;
               end else begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_alu <= w_alu_res;
               if (w_op == c_op_beq) begin
                  if (r_a == r_b) r_pc <= r_pc + {r_imm[29:0], 2'b00};
                  r_state <= ST_FETCH;
               end else if (w_op == c_op_lw || w_op == c_op_sw) begin
                  r_state <= ST_MEM;
               end else begin
                  r_state <= ST_WB;
               end
            end
            ST_MEM: begin
               if (w_op == c_op_lw) begin
                  r_mdr   <= r_dmem[r_alu[DMEM_AW+1:2]];
                  r_state <= ST_WB;
               end else begin
                  r_state <= ST_FETCH;
               end
            end
            ST_WB: begin
               if (w_dest != 5'd0) begin
                  r_wb_valid <= 1'b1;
                  r_wb_reg   <= w_dest;
                  r_wb_data  <= w_wb_val;
               end
               r_state <= ST_FETCH;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign pc       = r_pc;
   assign halted   = r_halted;
   assign err      = r_err;
   assign wb_valid = r_wb_valid;
   assign wb_reg   = r_wb_reg;
   assign wb_data  = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_core
// Description : Self-checking bench: directed programs plus random programs
//               compared against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_we = 1'b0;
   logic [9:0]  imem_addr = '0;
   logic [31:0] imem_wdata = '0;
   logic        start = 1'b0;
   logic [31:0] pc;
   logic        halted, err, wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [31:0] m_imem [1024];
   logic [31:0] m_dmem [1024];
   logic [31:0] m_rf   [32];
   int          exp_reg[$];
   logic [31:0] exp_data[$];
   int          exp_cycles;
   logic [31:0] exp_pc;
   logic        exp_err;

   logic [31:0] prog [64];
   logic [31:0] last_wb;

   mips_multicycle_core #(.IMEM_AW(10), .DMEM_AW(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .start      (start),
      .pc         (pc),
      .halted     (halted),
      .err        (err),
      .wb_valid   (wb_valid),
      .wb_reg     (wb_reg),
      .wb_data    (wb_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   task automatic model_write(input logic [4:0] d, input logic [31:0] v);
      if (d != 5'd0) begin
         m_rf[d] = v;
         exp_reg.push_back(int'(d));
         exp_data.push_back(v);
      end
   endtask

   // Instruction-level model: executes the program, predicts writebacks,
   // total cycles from start to halted, final pc and error flag
   task automatic run_model();
      logic [31:0] p, w, a, b, sx, ea;
      logic [5:0]  op, fn;
      bit          ok;
      p = 0; exp_cycles = 0; exp_err = 0;
      exp_reg.delete(); exp_data.delete();
      for (int steps = 0; steps < 2000; steps++) begin
         w = m_imem[p[11:2]];
         p = p + 4;
         if (w == 32'hFFFF_FFFF) begin exp_cycles += 2; break; end
         op = w[31:26]; fn = w[5:0];
         a  = m_rf[w[25:21]]; b = m_rf[w[20:16]];
         sx = {{16{w[15]}}, w[15:0]};
         ea = a + sx;
         ok = (op == 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 42)) ||
              op == 8 || op == 35 || op == 43 || op == 4;
         if (!ok) begin exp_cycles += 2; exp_err = 1; break; end
         case (op)
            6'd0: begin
               exp_cycles += 4;
               case (fn)
                  6'd32:   model_write(w[15:11], a + b);
                  6'd34:   model_write(w[15:11], a - b);
                  6'd36:   model_write(w[15:11], a & b);
                  6'd37:   model_write(w[15:11], a | b);
                  default: model_write(w[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
               endcase
            end
            6'd8:  begin exp_cycles += 4; model_write(w[20:16], ea); end
            6'd35: begin exp_cycles += 5; model_write(w[20:16], m_dmem[ea[11:2]]); end
            6'd43: begin exp_cycles += 4; m_dmem[ea[11:2]] = b; end
            default: begin exp_cycles += 3; if (a == b) p = p + (sx * 4); end
         endcase
      end
      exp_pc = p;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; imem_we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
   endtask

   task automatic load_word(input int addr, input logic [31:0] data);
      @(negedge clk);
      imem_we = 1'b1; imem_addr = addr[9:0]; imem_wdata = data;
      m_imem[addr] = data;
      @(negedge clk);
      imem_we = 1'b0;
   endtask

   // Load (word 0 written in the start cycle), start, and follow the run
   // cycle by cycle; n_stop > 0 asserts rst before that edge instead
   task automatic run_prog(input string name, input int n, input bit reload, input int n_stop);
      int  cyc;
      int  hcyc;
      if (reload) begin
         for (int i = 1; i < n; i++) load_word(i, prog[i]);
         m_imem[0] = prog[0];
      end
      run_model();
      @(negedge clk);
      if (reload) begin imem_we = 1'b1; imem_addr = '0; imem_wdata = prog[0]; end
      start = 1'b1;
      @(negedge clk);
      imem_we = 1'b0; start = 1'b0;
      hcyc = 0;
      for (cyc = 1; cyc <= 3000; cyc++) begin
         if (n_stop > 0 && cyc == n_stop) begin
            @(negedge clk); rst = 1'b1;
         end
         @(posedge clk); #1;
         if (n_stop > 0 && cyc == n_stop) break;
         if (cyc == 2 && n >= 2 && exp_cycles > 6) begin
            imem_we = 1'b1; imem_addr = 10'(n - 1); imem_wdata = 32'hFC00_0000;
         end
         if (cyc == 3) imem_we = 1'b0;
         if (wb_valid) begin
            if (exp_reg.size() == 0) check({name, "_extra_wb"}, {27'd0, wb_reg}, 32'hFFFF_FFFF);
            else begin
               check({name, "_wb_reg"}, {27'd0, wb_reg}, 32'(exp_reg.pop_front()));
               check({name, "_wb_data"}, wb_data, exp_data.pop_front());
            end
            last_wb = wb_data;
         end
         if (halted) begin hcyc = cyc; break; end
      end
      imem_we = 1'b0;
      if (n_stop > 0) return;
      check({name, "_halted"}, {31'd0, halted}, 32'd1);
      check({name, "_cycles"}, 32'(hcyc), 32'(exp_cycles));
      check({name, "_pc"}, pc, exp_pc);
      check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check({name, "_wb_left"}, 32'(exp_reg.size()), 32'd0);
   endtask

   // Random program: seeds, ALU ops, stores/loads at known addresses,
   // forward branches, then HALT
   task automatic gen_random(output int n);
      int offs[$];
      int k, kind;
      n = $urandom_range(6, 14);
      for (int i = 0; i < n; i++) begin
         kind = (i < 3) ? 0 : $urandom_range(0, 5);
         if (kind == 4 && offs.size() == 0) kind = 3;
         case (kind)
            0: prog[i] = enc_i(8, 0, $urandom_range(1, 12), $urandom_range(0, 65535));
            1, 2: prog[i] = enc_r($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 31),
                                  (int'($urandom_range(0, 4)) == 0) ? 32 :
                                  (int'($urandom_range(0, 3)) == 0) ? 34 :
                                  (int'($urandom_range(0, 2)) == 0) ? 36 :
                                  (int'($urandom_range(0, 1)) == 0) ? 37 : 42);
            3: begin
               k = 4 * $urandom_range(0, 15);
               offs.push_back(k);
               prog[i] = enc_i(43, 0, $urandom_range(0, 12), k);
            end
            4: prog[i] = enc_i(35, 0, $urandom_range(0, 12), offs[$urandom_range(0, offs.size() - 1)]);
            default: begin
               k = n - 1 - i;
               if (k > 2) k = 2;
               prog[i] = enc_i(4, $urandom_range(0, 2) * 4, $urandom_range(0, 2) * 4, $urandom_range(0, k));
            end
         endcase
      end
      prog[n] = 32'hFFFF_FFFF;
      n = n + 1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 1024; i++) m_dmem[i] = '0;
      do_reset();
      @(posedge clk); #1;
      check("rst_pc", pc, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);

      // basic addi/add program, 14 cycles to halted
      prog[0] = enc_i(8, 0, 8, 5); prog[1] = enc_i(8, 0, 9, 3);
      prog[2] = enc_r(8, 9, 17, 32); prog[3] = 32'hFFFF_FFFF;
      run_prog("basic", 4, 1, 0);
      check("basic_cycles14", 32'(exp_cycles), 32'd14);
      check("basic_last", last_wb, 32'd8);

      // sub/and/or/slt with 3 and 5
      do_reset();
      prog[0] = enc_i(8, 0, 8, 3); prog[1] = enc_i(8, 0, 9, 5);
      prog[2] = enc_r(8, 9, 18, 34); prog[3] = enc_r(8, 9, 19, 36);
      prog[4] = enc_r(8, 9, 20, 37); prog[5] = enc_r(8, 9, 21, 42);
      prog[6] = 32'hFFFF_FFFF;
      run_prog("alu", 7, 1, 0);

      // build DEADBEEF by doubling, store then load it back
      do_reset();
      prog[0] = enc_i(8, 0, 8, 16'hDEAE);
      for (int i = 1; i <= 16; i++) prog[i] = enc_r(8, 8, 8, 32);
      prog[17] = enc_i(8, 8, 8, 16'hBEEF);
      prog[18] = enc_i(43, 0, 8, 4);
      prog[19] = enc_i(35, 0, 10, 4);
      prog[20] = 32'hFFFF_FFFF;
      run_prog("ldst", 21, 1, 0);
      check("ldst_value", last_wb, 32'hDEAD_BEEF);

      // beq not taken falls through
      do_reset();
      prog[0] = enc_i(8, 0, 8, 1); prog[1] = enc_i(4, 8, 0, 5);
      prog[2] = 32'hFFFF_FFFF;
      run_prog("beq_nt", 3, 1, 0);

      // $0 discards writes and reads zero
      do_reset();
      prog[0] = enc_i(8, 0, 0, 7); prog[1] = enc_r(0, 0, 9, 37);
      prog[2] = 32'hFFFF_FFFF;
      run_prog("zero", 3, 1, 0);

      // illegal word halts with err, then restart without rst clears err
      do_reset();
      prog[0] = enc_i(8, 0, 8, 1); prog[1] = 32'hFC00_0000;
      prog[2] = enc_i(8, 0, 9, 2); prog[3] = 32'hFFFF_FFFF;
      run_prog("illegal", 4, 1, 0);
      prog[0] = enc_i(8, 8, 11, 4); prog[1] = 32'hFFFF_FFFF;
      run_prog("restart", 2, 1, 0);

      // beq $0,$0,-1 spins on its own address
      do_reset();
      load_word(0, enc_i(4, 0, 0, 16'hFFFF));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         if (wb_valid) n++;
         if (c == 1) check("loop_pc_fetch", pc, 32'd4);
      end
      check("loop_pc", pc, 32'd0);
      check("loop_no_wb", 32'(n), 32'd0);
      check("loop_halted", {31'd0, halted}, 32'd0);

      // rst during EXEC of the add, then rerun from the same IMEM
      do_reset();
      prog[0] = enc_i(8, 0, 8, 5); prog[1] = enc_i(8, 0, 9, 3);
      prog[2] = enc_r(8, 9, 17, 32); prog[3] = 32'hFFFF_FFFF;
      run_prog("abort", 4, 1, 11);
      check("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("abort_wb_reg", {27'd0, wb_reg}, 32'd0);
      check("abort_wb_data", wb_data, 32'd0);
      check("abort_pc", pc, 32'd0);
      check("abort_halted", {31'd0, halted}, 32'd0);
      check("abort_pending", 32'(exp_reg.size()), 32'd1);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      run_prog("rerun", 4, 0, 0);

      // random programs against the model
      for (int t = 0; t < 10; t++) begin
         do_reset();
         gen_random(n);
         run_prog($sformatf("rand%0d", t), n, 1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
